// File: rtl/banco_reg_param.sv
// Parametrised register bank: one write port, two combinational read ports,
// hardwired zero register, optional write bypass and pending scoreboard.
module banco_reg_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] aw,
  input  logic [DATA_W-1:0] dataIn,
  input  logic [ADDR_W-1:0] ar1,
  input  logic [ADDR_W-1:0] ar2,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] arsv,
  output logic [DATA_W-1:0] dr1,
  output logic [DATA_W-1:0] dr2,
  output logic              pend1,
  output logic              pend2,
  output logic [ADDR_W:0]   cnt_pend
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;

  logic wr_ok;
  logic rsv_ok;
  logic set_new;
  logic clr_old;
  logic hit1;
  logic hit2;

  always_comb begin
    wr_ok   = we && (aw != '0);
    rsv_ok  = rsv && (arsv != '0);
    set_new = rsv_ok && !pend_q[arsv];
    // a same-address reservation keeps the bit set, so no decrement
    clr_old = wr_ok && pend_q[aw] && !(rsv_ok && (arsv == aw));
  end

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_d[i] = '0;
      end
      pend_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr_ok) begin
        regs_d[aw] = dataIn;
        pend_d[aw] = 1'b0;
      end
      if (rsv_ok) begin
        pend_d[arsv] = 1'b1;
      end
      cnt_d = cnt_q
            + {{ADDR_W{1'b0}}, set_new}
            - {{ADDR_W{1'b0}}, clr_old};
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
    pend_q <= pend_d;
    cnt_q  <= cnt_d;
  end

  always_comb begin
    hit1 = BYPASS && wr_ok && (aw == ar1);
    hit2 = BYPASS && wr_ok && (aw == ar2);
  end

  always_comb begin
    dr1   = (ar1 == '0) ? '0 : regs_q[ar1];
    pend1 = (ar1 == '0) ? 1'b0 : pend_q[ar1];
    if (hit1) begin
      dr1   = dataIn;
      pend1 = 1'b0;
    end
  end

  always_comb begin
    dr2   = (ar2 == '0) ? '0 : regs_q[ar2];
    pend2 = (ar2 == '0) ? 1'b0 : pend_q[ar2];
    if (hit2) begin
      dr2   = dataIn;
      pend2 = 1'b0;
    end
  end

  assign cnt_pend = cnt_q;

endmodule

// File: doc/banco_reg_param.md
# banco_reg_param

Parametrised register bank for the datapath: one synchronous write port, two combinational read ports, a hardwired zero register, optional write-to-read bypass, and a per-register pending (scoreboard) bit with a live pending count. It replaces the fixed 32x32 bank between the decode stage (read addresses, reservations) and the ALU/writeback path (write port). The decode stage uses the pending flags to stall on read-after-write hazards.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- we  in  1  write enable
- aw  in  ADDR_W  write address
- dataIn  in  DATA_W  write data
- ar1  in  ADDR_W  read address, port 1
- ar2  in  ADDR_W  read address, port 2
- rsv  in  1  reserve request: mark register arsv pending
- arsv  in  ADDR_W  address to reserve
- dr1  out  DATA_W  read data, port 1 (combinational)
- dr2  out  DATA_W  read data, port 2 (combinational)
- pend1  out  1  register ar1 pending (combinational)
- pend2  out  1  register ar2 pending (combinational)
- cnt_pend  out  ADDR_W+1  number of pending registers (registered)

## Operation
- Storage: 2**ADDR_W registers of DATA_W bits plus 2**ADDR_W pending bits.
- Register 0: always reads 0; writes to address 0 ignored; reserving address 0 ignored; pend for address 0 always 0.
- Write: at edge with we=1 and aw!=0, reg[aw] <= dataIn and pending[aw] <= 0 (unless same-cycle reservation, below).
- Reserve: at edge with rsv=1 and arsv!=0, pending[arsv] <= 1.
- Simultaneous we and rsv to same nonzero address: reservation wins, pending stays/becomes 1, data still written (new producer issued as old one retires).
- Read, BYPASS=1: if we=1 and aw==arN and aw!=0, drN = dataIn and pendN = 0; otherwise drN = reg[arN], pendN = pending[arN].
- Read, BYPASS=0: drN = reg[arN], pendN = pending[arN]; no forwarding.
- Both read ports independent; ar1==ar2 legal and returns identical values.
- cnt_pend: population count of pending bits, maintained incrementally: +1 on set of a clear bit, -1 on clear of a set bit, net 0 when both happen on different addresses in one cycle; re-reserving an already-pending register does not increment; writing a non-pending register does not decrement. Never exceeds 2**ADDR_W - 1.

## Timing
- Reset: at edge with rst=1, all registers, pending bits and cnt_pend <= 0; we and rsv ignored that cycle. After reset dr1=dr2=0 (BYPASS may forward dataIn), pend1=pend2=0, cnt_pend=0.
- Reset mid-operation discards all reservations and data; no pending state survives.
- Write latency: stored value visible on drN the cycle after the edge; with BYPASS=1 visible combinationally in the same cycle.
- Reservation latency: pendN rises the cycle after the rsv edge; not forwarded combinationally.
- cnt_pend updates on the same edge as the pending bits it reflects.
- No handshake; we and rsv sampled every edge, no back-pressure.

## Test plan
- Reset then read all addresses -> dr1=dr2=0, pend1=pend2=0, cnt_pend=0.
- we=1, aw=1, dataIn=100; next cycle aw=2, dataIn=200; then ar1=1, ar2=2 -> dr1=100, dr2=200; BYPASS=1 with ar1=3 while writing aw=3, dataIn=300 -> dr1=300 same cycle (BYPASS=0 -> dr1=0 until next cycle).
- we=1, aw=0, dataIn=0xFFFFFFFF; rsv=1, arsv=0 -> dr1 at ar1=0 stays 0, pend1=0, cnt_pend=0.
- rsv arsv=4, then arsv=5, then arsv=4 again -> cnt_pend 1,2,2; pend1=1 at ar1=4; write aw=4, dataIn=400 -> next cycle pend1=0, cnt_pend=1, dr1=400.
- Same cycle rsv arsv=5 and we aw=5 dataIn=500 with 5 pending -> pending[5] stays 1, cnt_pend unchanged, dr at 5 =500; same cycle rsv arsv=6 and we aw=5 -> cnt_pend unchanged net.
- Reserve 3 registers, assert rst for one cycle with we=1 -> all pend 0, cnt_pend=0, written address reads 0.
